sprite_object: RTL
==================

# sprite_object

Single Atari-style player sprite generator for the console's video path. It sits between the CPU register bus and the pixel colour mux. It takes register writes and the HDMI timing signals (`hpos`, `vpos`, `in_image`, `in_vblank`) and produces a registered per-pixel sprite hit and colour, which the mux overlays on the playfield colour. It also latches a sticky sprite/playfield collision flag.

## Interface
Parameters:
- `H_VISIBLE`, 720: visible pixels per line.
- `POS_WIDTH`, 10: width of `hpos`, `vpos` and `XPOS`.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `write_enable`  in  1  register write strobe, one cycle, already in the `clk` domain.
- `address`  in  3  register select.
- `data_in`  in  8  write data.
- `hpos`  in  10  pixel column within the line; 0 = first visible pixel.
- `vpos`  in  10  line number.
- `in_image`  in  1  high during visible pixels.
- `in_vblank`  in  1  high during vertical blank.
- `playfield_fg`  in  1  playfield foreground bit, aligned with `pixel_on`.
- `pixel_on`  out  1  sprite pixel present (registered).
- `pixel_color`  out  7  sprite colour; 0 when `pixel_on` = 0.
- `collision`  out  1  sticky sprite/playfield overlap flag.

## Operation
- Register map (write-only shadows):
  - 0 `GRP`: 8-bit graphics.
  - 1 `COLOR[6:0]`.
  - 2 `XPOS[7:0]`.
  - 3 `XPOS[9:8]`, taken from `data_in[1:0]`.
  - 4 `CTRL`: `[1:0]` size, where 0/1/2/3 = 2/4/8/16 px per bit; `[2]` reflect; `[3]` enable.
  - 5 `YTOP`, in units of `vpos[9:1]`.
  - 6 `HEIGHT`, same units.
  - 7 any write clears `collision`.
- Double buffering: `GRP`, `COLOR`, `XPOS`, `CTRL` copy shadow→active on the cycle `in_image` goes 1→0, and on every cycle `in_vblank` = 1. `YTOP` and `HEIGHT` are used directly.
- Vertical window: `line = vpos[9:1]`. The line is active when `line >= YTOP` and `(line - YTOP)` < `HEIGHT`, using 9-bit unsigned arithmetic. `HEIGHT` = 0 means the sprite is never shown.
- State machine, with states IDLE, DRAW, DONE:
  - IDLE→DRAW when `in_image` && `hpos == XPOS` && enable && vertical window active. This loads the bit index (7, or 0 when reflect = 1) and a repeat counter of `(2 << size) - 1`.
  - In DRAW:
    - Output bit = `GRP_active[bit_index]`.
    - The repeat counter decrements each cycle. When it reaches 0 it reloads, and the bit index steps (−1, or +1 when reflect).
    - After the last repeat of the last bit → DONE.
  - DONE→IDLE when `in_image` = 0. Only one draw per line.
  - DRAW→IDLE immediately when `in_image` = 0; the sprite is clipped at the right edge.
- `XPOS` ≥ `H_VISIBLE` never triggers a draw.
- `pixel_color` = `COLOR_active` when `pixel_on`, else 0.
- Collision: set when `pixel_on` && `playfield_fg`. If set and clear (write to address 7) happen in the same cycle, set wins.

## Timing
- Reset:
  - All shadows and actives = 0.
  - State = IDLE.
  - `pixel_on` = 0, `pixel_color` = 0, `collision` = 0.
- Latency: the pixel for sample `hpos` = N appears on `pixel_on` in the cycle after `hpos` = N is presented. The first lit pixel corresponds to `hpos == XPOS`.
- Sprite width is 8 × (2 << size) cycles: 16, 32, 64 or 128.
- A register write takes effect in a shadow the cycle after the strobe. It reaches the display at the next active copy, never mid-line.
- `collision` updates the cycle after the overlapping `pixel_on`/`playfield_fg` pair.
- Reset asserted mid-DRAW: state, outputs and registers are forced to reset values on the next edge.

## Structure
- Package `video_pkg`:
  - Register address constants `SPR_GRP` … `SPR_COLCLR`.
  - State enum.
  - Size encoding.
  - `H_VISIBLE`.
- Single module with no sub-module. Datapath: shadow/active registers, vertical compare, bit index and repeat counters, output and collision flops.

## Test plan
- `GRP`=0xA5, `XPOS`=100, size 0, `YTOP`=0, `HEIGHT`=255, enable, after vblank copy → lit pixels at `hpos` 100–101, 104–105, 110–111, 114–115 (two cycles each), colour = `COLOR`; everything else 0.
- Same setup with reflect = 1 and `GRP`=0x01 → only `hpos` 100–101 lit. Size 3 with `GRP`=0xFF → 128 contiguous lit pixels.
- `XPOS`=700, size 1 → lit `hpos` 700–719 only; state back to IDLE when `in_image` falls; no wrap onto the next line.
- `YTOP`=10, `HEIGHT`=2 → lit only for `vpos` 20–23; `HEIGHT`=0 → never lit.
- Write `GRP` mid-line → current line unchanged; new value from the next line. Reset mid-DRAW → `pixel_on`=0 on the next cycle.
- Overlap with `playfield_fg`=1 → `collision`=1 and it stays set. A write to address 7 in the same cycle as a new overlap → stays 1. A clear with no overlap → 0.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared constants and types for the sprite object: register
//                map, draw state encoding and horizontal size encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Visible pixels per line (default for the sprite's H_VISIBLE parameter)
  localparam int H_VISIBLE = 720;

  // Register map
  localparam logic [2:0] SPR_GRP     = 3'd0;
  localparam logic [2:0] SPR_COLOR   = 3'd1;
  localparam logic [2:0] SPR_XPOS_LO = 3'd2;
  localparam logic [2:0] SPR_XPOS_HI = 3'd3;
  localparam logic [2:0] SPR_CTRL    = 3'd4;
  localparam logic [2:0] SPR_YTOP    = 3'd5;
  localparam logic [2:0] SPR_HEIGHT  = 3'd6;
  localparam logic [2:0] SPR_COLCLR  = 3'd7;

  // Draw state machine
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } spr_state_t;

  // Horizontal stretch: pixels per graphics bit
  typedef enum logic [1:0] {
    SIZE_2PX  = 2'd0,
    SIZE_4PX  = 2'd1,
    SIZE_8PX  = 2'd2,
    SIZE_16PX = 2'd3
  } spr_size_t;

  // Repeat-counter reload: pixels per bit minus one (1, 3, 7, 15)
  function automatic logic [3:0] rep_reload(input spr_size_t size);
    return 4'((5'd2 << size) - 5'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_object.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_object
//  Description : Single Atari-style player sprite. Double-buffered registers,
//                vertical window, per-line draw FSM with horizontal stretch
//                and reflect, registered pixel/colour and sticky collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_object #(
  parameter int H_VISIBLE = video_pkg::H_VISIBLE,
  parameter int POS_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [2:0]           address,
  input  logic [7:0]           data_in,
  input  logic [POS_WIDTH-1:0] hpos,
  input  logic [POS_WIDTH-1:0] vpos,
  input  logic                 in_image,
  input  logic                 in_vblank,
  input  logic                 playfield_fg,
  output logic                 pixel_on,
  output logic [6:0]           pixel_color,
  output logic                 collision
);
  import video_pkg::*;

  localparam int                   LINE_W     = POS_WIDTH - 1;
  localparam logic [POS_WIDTH-1:0] XPOS_LIMIT = POS_WIDTH'(H_VISIBLE);

  // Shadow (CPU-written) and active (displayed) registers
  logic [7:0]           grp_sh_q,   grp_act_q;
  logic [6:0]           color_sh_q, color_act_q;
  logic [POS_WIDTH-1:0] xpos_sh_q,  xpos_act_q;
  logic [3:0]           ctrl_sh_q,  ctrl_act_q;
  logic [7:0]           ytop_q, height_q;
  logic                 in_image_q;

  // Draw engine
  spr_state_t state_q;
  logic [2:0] bit_idx_q;
  logic [3:0] rep_q;
  logic       pixel_on_q;
  logic [6:0] pixel_color_q;
  logic       collision_q;

  logic              copy_active;
  logic [LINE_W-1:0] line, line_off;
  logic              line_active;
  logic              reflect, draw_start;
  logic [2:0]        start_idx, last_idx;
  logic [3:0]        rep_load;
  logic              col_clear;
  logic              unused_vpos_lsb;

  // Shadows become visible at the end of each visible run and throughout vblank
  assign copy_active = (in_image_q && !in_image) || in_vblank;

  // Vertical window on double-scanned lines; wrap-around of line - YTOP is harmless
  // because line >= YTOP is required as well
  assign line        = vpos[POS_WIDTH-1:1];
  assign line_off    = line - LINE_W'(ytop_q);
  assign line_active = (line >= LINE_W'(ytop_q)) && (line_off < LINE_W'(height_q));
  assign unused_vpos_lsb = vpos[0];

  assign reflect    = ctrl_act_q[2];
  assign start_idx  = reflect ? 3'd0 : 3'd7;
  assign last_idx   = reflect ? 3'd7 : 3'd0;
  assign rep_load   = rep_reload(spr_size_t'(ctrl_act_q[1:0]));
  assign draw_start = in_image && (hpos == xpos_act_q) && (xpos_act_q < XPOS_LIMIT)
                      && ctrl_act_q[3] && line_active;

  assign col_clear = write_enable && (address == SPR_COLCLR);

  // CPU register writes into shadows, and shadow-to-active copies
  always_ff @(posedge clk) begin
    if (reset) begin
      grp_sh_q    <= '0;
      color_sh_q  <= '0;
      xpos_sh_q   <= '0;
      ctrl_sh_q   <= '0;
      ytop_q      <= '0;
      height_q    <= '0;
      grp_act_q   <= '0;
      color_act_q <= '0;
      xpos_act_q  <= '0;
      ctrl_act_q  <= '0;
      in_image_q  <= 1'b0;
    end else begin
      in_image_q <= in_image;
      if (write_enable) begin
        case (address)
          SPR_GRP:     grp_sh_q                   <= data_in;
          SPR_COLOR:   color_sh_q                 <= data_in[6:0];
          SPR_XPOS_LO: xpos_sh_q[7:0]             <= data_in;
          SPR_XPOS_HI: xpos_sh_q[POS_WIDTH-1:8]   <= data_in[POS_WIDTH-9:0];
          SPR_CTRL:    ctrl_sh_q                  <= data_in[3:0];
          SPR_YTOP:    ytop_q                     <= data_in;
          SPR_HEIGHT:  height_q                   <= data_in;
          default:     ;
        endcase
      end
      if (copy_active) begin
        grp_act_q   <= grp_sh_q;
        color_act_q <= color_sh_q;
        xpos_act_q  <= xpos_sh_q;
        ctrl_act_q  <= ctrl_sh_q;
      end
    end
  end

  // Draw FSM with registered pixel outputs. The trigger cycle already emits the
  // first pixel, so the repeat counter is loaded pre-decremented there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      rep_q         <= '0;
      pixel_on_q    <= 1'b0;
      pixel_color_q <= '0;
    end else begin
      pixel_on_q    <= 1'b0;
      pixel_color_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (draw_start) begin
            state_q       <= ST_DRAW;
            bit_idx_q     <= start_idx;
            rep_q         <= rep_load - 4'd1;
            pixel_on_q    <= grp_act_q[start_idx];
            pixel_color_q <= grp_act_q[start_idx] ? color_act_q : 7'd0;
          end
        end
        ST_DRAW: begin
          if (!in_image) begin
            state_q <= ST_IDLE;               // clipped at the right edge
          end else begin
            pixel_on_q    <= grp_act_q[bit_idx_q];
            pixel_color_q <= grp_act_q[bit_idx_q] ? color_act_q : 7'd0;
            if (rep_q == 4'd0) begin
              if (bit_idx_q == last_idx) begin
                state_q <= ST_DONE;
              end else begin
                bit_idx_q <= reflect ? bit_idx_q + 3'd1 : bit_idx_q - 3'd1;
                rep_q     <= rep_load;
              end
            end else begin
              rep_q <= rep_q - 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (!in_image) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky collision; a new overlap beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else if (pixel_on_q && playfield_fg) begin
      collision_q <= 1'b1;
    end else if (col_clear) begin
      collision_q <= 1'b0;
    end
  end

  assign pixel_on    = pixel_on_q;
  assign pixel_color = pixel_color_q;
  assign collision   = collision_q;

endmodule
`default_nettype wire
